// File: rtl/mux4_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter_pkg
//
// Shared definitions for the round-robin arbiter that owns the select input
// of the 4-to-1 multiplexer datapath.
//
//   NREQ     number of requesters competing for the mux output channel
//   SEL_W    width of the mux select code
//   state_e  arbiter FSM state encoding (IDLE / GRANT / GAP)
//   onehot() converts a requester index into a one-hot grant vector
// -----------------------------------------------------------------------------
package mux4_rr_arbiter_pkg;

    localparam int NREQ  = 4;
    localparam int SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,  // no grant, arbitrating on every cycle
        GRANT = 2'd1,  // one owner holds the channel
        GAP   = 2'd2   // single dead cycle after a release
    } state_e;

    // One-hot grant vector for requester 'idx'.
    function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NREQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage : mux4_rr_arbiter_pkg

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// -----------------------------------------------------------------------------
// rr_pick4
//
// Purely combinational rotating-priority picker. Searches the request vector
// starting at 'ptr' and wrapping modulo 4 (ptr, ptr+1, ptr+2, ptr+3), and
// returns the first requester found.
//
// Ports:
//   req   [3:0]  in   request lines, bit k = requester k
//   ptr   [1:0]  in   index with the highest priority this cycle
//   valid        out  at least one request is set
//   idx   [1:0]  out  winning requester index (equals ptr when !valid)
// -----------------------------------------------------------------------------
module rr_pick4
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             valid,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    // NOTE: every variable assigned in an always_comb block receives a default
    // at the top so no path leaves it unassigned; that is what keeps a latch
    // from being inferred.
    always_comb begin
        valid = 1'b0;
        idx   = ptr;
        cand  = ptr;
        // Walk from the lowest priority offset to the highest; the last hit
        // written is therefore the one closest to ptr, which is the winner.
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);  // wraps modulo 4 through the 2-bit width
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule : rr_pick4

// File: rtl/mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter
//
// Round-robin arbiter and sequencer for the shared 4-to-1 multiplexer. One
// requester at a time owns the mux output channel; the block drives the mux
// select code and bounds each tenure to MAX_HOLD cycles. Every release is
// followed by a single dead (GAP) cycle and then an IDLE arbitration cycle,
// so the select code never moves while a grant is active.
//
// Parameters:
//   MAX_HOLD  longest tenure in cycles before a forced release (1..255)
//   CNT_W     hold counter width, 2**CNT_W must exceed MAX_HOLD
//
// Ports:
//   clk          in   system clock, all state changes on the rising edge
//   rst          in   synchronous active-high reset
//   req   [3:0]  in   level-sensitive request lines
//   done         in   current owner ends its transfer (ignored without grant)
//   grant [3:0]  out  one-hot grant, at most one bit set
//   sel   [1:0]  out  mux select; index of the grant bit while granted,
//                     otherwise the last owner's index
//   busy         out  a grant is active
//   forced       out  one-cycle pulse (the GAP cycle) when a tenure ended
//                     purely because MAX_HOLD expired
// -----------------------------------------------------------------------------
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 15,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic             done,
    output logic [NREQ-1:0]  grant,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             forced
);

    localparam logic [CNT_W-1:0] MAX_HOLD_C = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e           state_q;
    logic [NREQ-1:0]  grant_q;
    logic [SEL_W-1:0] sel_q;    // doubles as the owner index while in GRANT
    logic [SEL_W-1:0] ptr_q;    // highest-priority requester for next pick
    logic [CNT_W-1:0] cnt_q;    // cycles held so far in the current tenure
    logic             busy_q;
    logic             forced_q;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    logic             pick_valid;
    logic [SEL_W-1:0] pick_idx;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // -------------------------------------------------------------------------
    // Release decode (only meaningful in GRANT)
    // -------------------------------------------------------------------------
    logic             rel_done_d;
    logic             rel_drop_d;
    logic             rel_expire_d;
    logic             release_d;
    logic             forced_d;
    logic [SEL_W-1:0] ptr_d;

    always_comb begin
        rel_done_d   = done;
        rel_drop_d   = ~req[sel_q];
        rel_expire_d = (cnt_q == MAX_HOLD_C);
        release_d    = rel_done_d | rel_drop_d | rel_expire_d;
        // Expiry counts as forced only when nothing else ended the tenure.
        forced_d     = rel_expire_d & ~rel_done_d & ~rel_drop_d;
        ptr_d        = sel_q + SEL_W'(1);
    end

    // -------------------------------------------------------------------------
    // FSM with registered outputs
    // -------------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every register in
    // this block samples the values from before the edge, regardless of
    // statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            sel_q    <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            forced_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    forced_q <= 1'b0;
                    if (pick_valid) begin
                        state_q <= GRANT;
                        grant_q <= onehot(pick_idx);
                        sel_q   <= pick_idx;
                        cnt_q   <= CNT_ONE;
                        busy_q  <= 1'b1;
                    end
                end

                GRANT: begin
                    if (release_d) begin
                        state_q  <= GAP;
                        grant_q  <= '0;
                        busy_q   <= 1'b0;
                        ptr_q    <= ptr_d;
                        forced_q <= forced_d;
                    end else if (cnt_q != MAX_HOLD_C) begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                GAP: begin
                    // sel_q deliberately untouched: the mux keeps the last
                    // owner's input selected while nobody holds a grant.
                    state_q  <= IDLE;
                    forced_q <= 1'b0;
                end

                default: begin
                    state_q  <= IDLE;
                    grant_q  <= '0;
                    busy_q   <= 1'b0;
                    forced_q <= 1'b0;
                end
            endcase
        end
    end

    assign grant  = grant_q;
    assign sel    = sel_q;
    assign busy   = busy_q;
    assign forced = forced_q;

endmodule : mux4_rr_arbiter
